// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and types for the 10GBASE-R receive PCS.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int unsigned LOCK_SH_COUNT      = 64;
  localparam int unsigned LOCK_INVALID_LIMIT = 16;
  localparam int unsigned BER_ERR_LIMIT      = 16;
  localparam int unsigned WDOG_WINDOW_LIMIT  = 8;

  typedef enum logic [1:0] {
    LOCK_TEST = 2'd0,
    SLIP_HIGH = 2'd1,
    SLIP_WAIT = 2'd2
  } lock_state_t;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// Header error-rate monitor: counts invalid sync headers per window while
// block lock is held and flags a high bit error rate.
module eth_phy_10g_rx_ber_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned COUNT_125US = 125
) (
  input  logic rx_clk,
  input  logic rx_rst,
  input  logic block_lock,
  input  logic hdr_err,
  output logic rx_high_ber
);

  localparam int unsigned WIN_W = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;

  logic [WIN_W-1:0] win_cnt;
  logic [4:0]       err_cnt;
  logic [4:0]       err_next;
  logic             win_end;
  logic             ber_trip;

  assign win_end  = (win_cnt == WIN_W'(COUNT_125US - 1));
  assign ber_trip = (err_next == 5'(BER_ERR_LIMIT));

  // Saturating error count including the header sampled this cycle.
  always_comb begin
    err_next = err_cnt;
    if (hdr_err && (err_cnt != 5'(BER_ERR_LIMIT)))
      err_next = err_cnt + 5'd1;
  end

  // Window timing, error accumulation and the high-BER flag; all of it is
  // held cleared while lock is absent.
  always_ff @(posedge rx_clk) begin
    if (rx_rst || !block_lock) begin
      win_cnt     <= '0;
      err_cnt     <= '0;
      rx_high_ber <= 1'b0;
    end else if (win_end) begin
      win_cnt     <= '0;
      err_cnt     <= '0;
      rx_high_ber <= ber_trip;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      err_cnt <= err_next;
      if (ber_trip)
        rx_high_ber <= 1'b1;
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_lock.sv
// 10GBASE-R receive block lock: sync-header based lock FSM with SERDES
// bitslip control, link status and a SERDES reset watchdog.
module eth_phy_10g_rx_lock
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned HDR_WIDTH           = 2,
  parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
  parameter int unsigned BITSLIP_LOW_CYCLES  = 8,
  parameter int unsigned COUNT_125US         = 125
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  output logic                 serdes_rx_bitslip,
  output logic                 serdes_rx_reset_req,
  output logic                 rx_block_lock,
  output logic                 rx_high_ber,
  output logic                 rx_status
);

  localparam int unsigned SLIP_CNT_MAX =
    (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ? BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int unsigned SLIP_W = (SLIP_CNT_MAX > 1) ? $clog2(SLIP_CNT_MAX + 1) : 1;
  localparam int unsigned WIN_W  = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;

  lock_state_t       state;
  logic [SLIP_W-1:0] slip_cnt;
  logic [5:0]        sh_cnt;
  logic [4:0]        sh_invalid_cnt;
  logic              hdr_ok;

  logic [WIN_W-1:0]  win_cnt;
  logic              win_end;
  logic              win_good;
  logic              link_ok;
  logic              good_now;
  logic              status_next;
  logic [2:0]        wdog_cnt;

  assign hdr_ok = hdr_valid(serdes_rx_hdr);

  // Block lock FSM. SLIP_WAIT with an expired counter evaluates the header
  // directly, so the cycle after reset (and the cycle after the ignore
  // period) already tests a header without a separate LOCK_TEST entry cycle.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state             <= SLIP_WAIT;
      slip_cnt          <= '0;
      sh_cnt            <= '0;
      sh_invalid_cnt    <= '0;
      rx_block_lock     <= 1'b0;
      serdes_rx_bitslip <= 1'b0;
    end else begin
      serdes_rx_bitslip <= 1'b0;
      case (state)
        SLIP_HIGH: begin
          if (slip_cnt != '0) begin
            slip_cnt          <= slip_cnt - 1'b1;
            serdes_rx_bitslip <= 1'b1;
          end else begin
            state    <= SLIP_WAIT;
            slip_cnt <= SLIP_W'(BITSLIP_LOW_CYCLES);
          end
        end
        LOCK_TEST, SLIP_WAIT: begin
          if ((state == SLIP_WAIT) && (slip_cnt != '0)) begin
            slip_cnt <= slip_cnt - 1'b1;
          end else begin
            state <= LOCK_TEST;
            if (!hdr_ok) begin
              if (!rx_block_lock ||
                  (sh_invalid_cnt == 5'(LOCK_INVALID_LIMIT - 1))) begin
                rx_block_lock     <= 1'b0;
                sh_cnt            <= '0;
                sh_invalid_cnt    <= '0;
                state             <= SLIP_HIGH;
                slip_cnt          <= SLIP_W'(BITSLIP_HIGH_CYCLES - 1);
                serdes_rx_bitslip <= 1'b1;
              end else if (sh_cnt == 6'(LOCK_SH_COUNT - 1)) begin
                sh_cnt         <= '0;
                sh_invalid_cnt <= '0;
              end else begin
                sh_cnt         <= sh_cnt + 6'd1;
                sh_invalid_cnt <= sh_invalid_cnt + 5'd1;
              end
            end else if (sh_cnt == 6'(LOCK_SH_COUNT - 1)) begin
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
              rx_block_lock  <= 1'b1;
            end else begin
              sh_cnt <= sh_cnt + 6'd1;
            end
          end
        end
        default: begin
          state    <= SLIP_WAIT;
          slip_cnt <= '0;
        end
      endcase
    end
  end

  eth_phy_10g_rx_ber_mon #(
    .COUNT_125US(COUNT_125US)
  ) u_ber_mon (
    .rx_clk      (rx_clk),
    .rx_rst      (rx_rst),
    .block_lock  (rx_block_lock),
    .hdr_err     (!hdr_ok),
    .rx_high_ber (rx_high_ber)
  );

  assign win_end = (win_cnt == WIN_W'(COUNT_125US - 1));
  assign link_ok = rx_block_lock && !rx_high_ber;

  // Whether the link has been healthy on every cycle of the current window.
  always_comb begin
    good_now    = win_good && link_ok;
    status_next = rx_status && link_ok;
    if (win_end)
      status_next = good_now;
  end

  // Free-running status window, link status and SERDES reset watchdog.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      win_cnt             <= '0;
      win_good            <= 1'b1;
      rx_status           <= 1'b0;
      wdog_cnt            <= '0;
      serdes_rx_reset_req <= 1'b0;
    end else begin
      serdes_rx_reset_req <= 1'b0;
      rx_status           <= status_next;
      if (win_end) begin
        win_cnt  <= '0;
        win_good <= 1'b1;
        if (status_next) begin
          wdog_cnt <= '0;
        end else if (wdog_cnt == 3'(WDOG_WINDOW_LIMIT - 1)) begin
          wdog_cnt            <= '0;
          serdes_rx_reset_req <= 1'b1;
        end else begin
          wdog_cnt <= wdog_cnt + 3'd1;
        end
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        win_good <= good_now;
      end
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_rx_lock.sv
// Self-checking bench for eth_phy_10g_rx_lock: directed header sequences
// push expected outputs into a scoreboard that a negedge monitor drains.
module tb_eth_phy_10g_rx_lock;

  localparam int SIG_BITSLIP = 0;
  localparam int SIG_RSTREQ  = 1;
  localparam int SIG_LOCK    = 2;
  localparam int SIG_HIBER   = 3;
  localparam int SIG_STATUS  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hdr = 2'b01;
  logic       bitslip, reset_req, block_lock, high_ber, status;

  eth_phy_10g_rx_lock #(
    .HDR_WIDTH          (2),
    .BITSLIP_HIGH_CYCLES(1),
    .BITSLIP_LOW_CYCLES (8),
    .COUNT_125US        (125)
  ) dut (
    .rx_clk             (clk),
    .rx_rst             (rst),
    .serdes_rx_hdr      (hdr),
    .serdes_rx_bitslip  (bitslip),
    .serdes_rx_reset_req(reset_req),
    .rx_block_lock      (block_lock),
    .rx_high_ber        (high_ber),
    .rx_status          (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sig;
    logic  val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   locked_runs = 0;

  function automatic void tally(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
    end
  endfunction

  task automatic expect_out(input int sig, input logic val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_idle(input string tag);
    expect_out(SIG_BITSLIP, 1'b0, {tag, ".bitslip"});
    expect_out(SIG_RSTREQ,  1'b0, {tag, ".reset_req"});
    expect_out(SIG_LOCK,    1'b0, {tag, ".lock"});
    expect_out(SIG_HIBER,   1'b0, {tag, ".high_ber"});
    expect_out(SIG_STATUS,  1'b0, {tag, ".status"});
  endtask

  // One header per clock edge; returns just after the edge that sampled it.
  task automatic step(input logic [1:0] h);
    hdr = h;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    hdr = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_idle("reset");
  endtask

  task automatic acquire_lock(input string tag);
    for (int i = 1; i <= 64; i++) begin
      step(2'b01);
      if (i == 63) expect_out(SIG_LOCK, 1'b0, {tag, ".lock_63"});
      if (i == 64) expect_out(SIG_LOCK, 1'b1, {tag, ".lock_64"});
    end
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    logic [4:0] outs;
    outs = {status, high_ber, block_lock, reset_req, bitslip};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: due at cycle %0d, seen at %0d, value required %b",
                 e.name, e.cyc, cyc, e.val);
      end else begin
        tally(e.name, outs[e.sig], e.val);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, %0d vectors, %0d miscompares",
             vectors, miscompares);
    $fatal(1, "timeout");
  end

  initial begin
    // Clean lock, then status after one fully healthy window.
    reset_dut();
    for (int i = 1; i <= 250; i++) begin
      step(2'b01);
      expect_out(SIG_BITSLIP, 1'b0, "clean.bitslip");
      if (i == 63)  expect_out(SIG_LOCK, 1'b0, "clean.lock_63");
      if (i == 64)  expect_out(SIG_LOCK, 1'b1, "clean.lock_64");
      if (i == 249) expect_out(SIG_STATUS, 1'b0, "clean.status_249");
      if (i == 250) expect_out(SIG_STATUS, 1'b1, "clean.status_250");
    end

    // Reset while locked and healthy, then relock.
    rst = 1'b1;
    step(2'b01);
    rst = 1'b0;
    expect_idle("rst_locked");
    acquire_lock("relock");

    // Invalid headers while unlocked: periodic slips and watchdog reset.
    reset_dut();
    for (int i = 1; i <= 1001; i++) begin
      step(2'b00);
      if (i <= 60)        expect_out(SIG_BITSLIP, ((i - 1) % 10) == 0, "unlocked.bitslip");
      if (i >= 999)       expect_out(SIG_RSTREQ, i == 1000, "unlocked.reset_req");
      if (i % 100 == 0)   expect_out(SIG_LOCK, 1'b0, "unlocked.lock");
    end

    // Loss of lock: 15 invalid holds, the 16th in a window drops lock.
    reset_dut();
    acquire_lock("lol");
    for (int i = 65; i <= 145; i++) begin
      step(((i <= 79) || (i >= 129 && i <= 144)) ? 2'b00 : 2'b01);
      if (i == 79) begin
        expect_out(SIG_LOCK, 1'b1, "lol.lock_15inv");
        expect_out(SIG_BITSLIP, 1'b0, "lol.bitslip_15inv");
      end
      if (i == 128) begin
        expect_out(SIG_LOCK, 1'b1, "lol.lock_window_end");
        expect_out(SIG_HIBER, 1'b0, "lol.high_ber_15err");
      end
      if (i == 129) expect_out(SIG_HIBER, 1'b1, "lol.high_ber_16err");
      if (i == 143) begin
        expect_out(SIG_LOCK, 1'b1, "lol.lock_15inv_b");
        expect_out(SIG_BITSLIP, 1'b0, "lol.bitslip_15inv_b");
      end
      if (i == 144) begin
        expect_out(SIG_LOCK, 1'b0, "lol.lock_16inv");
        expect_out(SIG_BITSLIP, 1'b1, "lol.bitslip_16inv");
      end
      if (i == 145) begin
        expect_out(SIG_HIBER, 1'b0, "lol.high_ber_cleared");
        expect_out(SIG_BITSLIP, 1'b0, "lol.bitslip_end");
      end
    end

    // High BER: 8 + 8 errors in one BER window, then a clean window.
    reset_dut();
    acquire_lock("ber");
    for (int i = 65; i <= 314; i++) begin
      step(((i >= 65 && i <= 72) || (i >= 129 && i <= 136)) ? 2'b00 : 2'b01);
      if (i == 135) expect_out(SIG_HIBER, 1'b0, "ber.high_ber_15");
      if (i == 136) begin
        expect_out(SIG_HIBER, 1'b1, "ber.high_ber_16");
        expect_out(SIG_LOCK, 1'b1, "ber.lock_held");
      end
      if (i == 250) begin
        expect_out(SIG_STATUS, 1'b0, "ber.status");
        expect_out(SIG_LOCK, 1'b1, "ber.lock_250");
      end
      if (i == 313) expect_out(SIG_HIBER, 1'b1, "ber.high_ber_313");
      if (i == 314) begin
        expect_out(SIG_HIBER, 1'b0, "ber.high_ber_clean");
        expect_out(SIG_LOCK, 1'b1, "ber.lock_314");
      end
    end

    // Sparse random header errors; lock should hold at the end of nearly all runs.
    for (int r = 0; r < 100; r++) begin
      reset_dut();
      for (int i = 1; i <= 300; i++)
        step(($urandom_range(999) == 0) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10));
      if (block_lock === 1'b1) locked_runs++;
    end
    tally("random.locked_runs_ge_95", locked_runs >= 95, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
